// File: rtl/bod_controller.sv
// Brown-out detection controller: periodic ADC sampling, threshold classification and debounced supervision.
// Optional BOD_HYST_EN adds HYST to the thresholds for recovery comparisons; undefined means zero hysteresis.
module bod_controller #(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned DEB_CNT    = 4,
`ifdef BOD_HYST_EN
  parameter int unsigned HYST       = 256,
`endif
  parameter int unsigned HOLD_CYC   = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [19:0] thresh_warn,
  input  logic [19:0] thresh_reset,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [19:0] adc_data,
  output logic        bod_warn,
  output logic        bod_reset,
  output logic        irq,
  output logic [1:0]  bod_state
);

  localparam int TMR_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SAMPLE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
  localparam logic [7:0]        DEB       = 8'(DEB_CNT);

  typedef enum logic [1:0] {S_OK = 2'd0, S_WARN = 2'd1, S_BO = 2'd2, S_HOLD = 2'd3} sup_t;
  typedef enum logic {SQ_IDLE = 1'b0, SQ_WAIT = 1'b1} seq_t;

  sup_t              state_q, state_d;
  seq_t              seq_q, seq_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        c_bo_q, c_bo_d, c_lo_q, c_lo_d, c_up_q, c_up_d;
  logic              start_q, start_d;
  logic              warn_q, warn_d, reset_q, reset_d, irq_q, irq_d;
  logic              sample_v, is_low, is_lm, up_w, up_r, up_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    is_low = adc_data < thresh_reset;
    is_lm  = adc_data < thresh_warn;
`ifdef BOD_HYST_EN
    up_w = {1'b0, adc_data} >= ({1'b0, thresh_warn} + 21'(HYST));
    up_r = {1'b0, adc_data} >= ({1'b0, thresh_reset} + 21'(HYST));
`else
    up_w = !is_lm;
    up_r = !is_low;
`endif
  end

  // Sequencer; the sample is only accepted after the adc_start cycle
  always_comb begin
    seq_d    = seq_q;
    timer_d  = timer_q;
    start_d  = 1'b0;
    sample_v = 1'b0;
    case (seq_q)
      SQ_IDLE: begin
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          start_d = 1'b1;
          seq_d   = SQ_WAIT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SQ_WAIT: begin
        if (adc_done && !start_q) begin
          sample_v = 1'b1;
          seq_d    = SQ_IDLE;
          timer_d  = '0;
        end
      end
      default: seq_d = SQ_IDLE;
    endcase
    if (!enable) begin
      seq_d    = SQ_IDLE;
      timer_d  = '0;
      start_d  = 1'b0;
      sample_v = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    c_bo_d  = c_bo_q;
    c_lo_d  = c_lo_q;
    c_up_d  = c_up_q;
    hold_d  = hold_q;
    irq_d   = 1'b0;
    up_sel  = (state_q == S_WARN) ? up_w : ((state_q == S_BO) ? up_r : 1'b0);
    if (state_q == S_HOLD && hold_q != '0) hold_d = hold_q - 1'b1;
    if (sample_v) begin
      c_bo_d = is_low ? sat_inc(c_bo_q) : 8'd0;
      c_lo_d = is_lm  ? sat_inc(c_lo_q) : 8'd0;
      c_up_d = up_sel ? sat_inc(c_up_q) : 8'd0;
      case (state_q)
        S_OK: begin
          if (c_bo_d >= DEB)      state_d = S_BO;
          else if (c_lo_d >= DEB) state_d = S_WARN;
        end
        S_WARN: begin
          if (c_bo_d >= DEB)      state_d = S_BO;
          else if (c_up_d >= DEB) state_d = S_OK;
        end
        S_BO: begin
          if (c_up_d >= DEB) begin
            state_d = S_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
        S_HOLD: if (is_low) state_d = S_BO;
        default: state_d = S_OK;
      endcase
    end
    // A LOW sample outranks hold expiry in the same cycle
    if (state_q == S_HOLD && state_d == S_HOLD && hold_q == '0) state_d = S_WARN;
    if (state_d != state_q) begin
      c_bo_d = 8'd0;
      c_lo_d = 8'd0;
      c_up_d = 8'd0;
    end
    if ((state_d == S_BO && state_q != S_BO) || (state_q == S_OK && state_d == S_WARN)) irq_d = 1'b1;
    warn_d  = (state_d != S_OK);
    reset_d = (state_d == S_BO) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OK;
      seq_q   <= SQ_IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      c_bo_q  <= 8'd0;
      c_lo_q  <= 8'd0;
      c_up_q  <= 8'd0;
      start_q <= 1'b0;
      warn_q  <= 1'b0;
      reset_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      c_bo_q  <= c_bo_d;
      c_lo_q  <= c_lo_d;
      c_up_q  <= c_up_d;
      start_q <= start_d;
      warn_q  <= warn_d;
      reset_q <= reset_d;
      irq_q   <= irq_d;
    end
  end

  assign adc_start = start_q;
  assign bod_warn  = warn_q;
  assign bod_reset = reset_q;
  assign irq       = irq_q;
  assign bod_state = state_q;

endmodule
